// File: rtl/instruction_loader.sv
// Byte-stream program loader: parses a 16-bit word count followed by MSB-first
// 32-bit words and writes each assembled word into the instruction RAM.
module instruction_loader #(
  parameter int unsigned MEM_DEPTH  = 31,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [31:0]           i_ram_input,
  output logic [ADDR_WIDTH-1:0] i_ram_writing_address,
  output logic                  flag_write_i_ram,
  output logic                  loading,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ASM_W  = 24;
  localparam int unsigned BCNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        idx_q, idx_d;
  logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
  logic [ASM_W-1:0]        asm_q, asm_d;
  logic [WORD_W-1:0]       ram_data_q, ram_data_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic                    strobe_q, strobe_d;
  logic                    ready_q, ready_d;
  logic                    loading_q, loading_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    xfer;
  logic [LEN_W-1:0]        len_full;
  logic [LEN_W-1:0]        idx_next;

  assign xfer     = byte_valid && ready_q;
  assign len_full = {len_q[LEN_W-1:8], byte_in};
  assign idx_next = idx_q + LEN_W'(1);

  // State and datapath registers; reset wins over every other update.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      ram_data_q <= '0;
      ram_addr_q <= '0;
      strobe_q   <= 1'b0;
      ready_q    <= 1'b0;
      loading_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      ram_data_q <= ram_data_d;
      ram_addr_q <= ram_addr_d;
      strobe_q   <= strobe_d;
      ready_q    <= ready_d;
      loading_q  <= loading_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic; status outputs are decoded from the next state so they
  // are registered yet always agree with the current state.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
    ram_data_d = ram_data_q;
    ram_addr_d = ram_addr_q;
    strobe_d   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          idx_d   = '0;
          bcnt_d  = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d   = {byte_in, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full == '0) begin
            state_d = S_DONE;
          end else if (len_full > LEN_W'(MEM_DEPTH)) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d  = {asm_q[ASM_W-9:0], byte_in};
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_W'(3)) begin
            state_d    = S_WRITE;
            strobe_d   = 1'b1;
            ram_data_d = {asm_q, byte_in};
            ram_addr_d = ADDR_WIDTH'(idx_q);
          end
        end
      end
      S_WRITE: begin
        idx_d   = idx_next;
        state_d = (idx_next == len_q) ? S_DONE : S_DATA;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d   = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA);
    loading_d = ready_d || (state_d == S_WRITE);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERROR);
  end

  assign byte_ready            = ready_q;
  assign i_ram_input           = ram_data_q;
  assign i_ram_writing_address = ram_addr_q;
  assign flag_write_i_ram      = strobe_q;
  assign loading               = loading_q;
  assign done                  = done_q;
  assign error                 = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: drives byte streams and compares the
// RAM write strobes and status flags against hand-computed expectations.
module tb_instruction_loader;

  localparam int unsigned MEM_DEPTH  = 31;
  localparam int unsigned ADDR_WIDTH = 10;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  start;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [31:0]           i_ram_input;
  logic [ADDR_WIDTH-1:0] i_ram_writing_address;
  logic                  flag_write_i_ram;
  logic                  loading;
  logic                  done;
  logic                  error;

  int errors = 0;
  int checks = 0;

  logic [31:0]           got_data[$];
  logic [ADDR_WIDTH-1:0] got_addr[$];
  logic [31:0]           exp_data[$];
  logic [ADDR_WIDTH-1:0] exp_addr[$];
  logic                  prev_flag = 1'b0;

  instruction_loader #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .byte_in              (byte_in),
    .byte_valid           (byte_valid),
    .byte_ready           (byte_ready),
    .i_ram_input          (i_ram_input),
    .i_ram_writing_address(i_ram_writing_address),
    .flag_write_i_ram     (flag_write_i_ram),
    .loading              (loading),
    .done                 (done),
    .error                (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: records every strobe cycle and checks strobe-cycle invariants.
  always @(negedge clock) begin
    if (flag_write_i_ram === 1'b1) begin
      got_addr.push_back(i_ram_writing_address);
      got_data.push_back(i_ram_input);
      check("ready_low_in_write", 32'(byte_ready), 32'd0);
      check("strobe_one_cycle", 32'(prev_flag), 32'd0);
    end
    prev_flag = flag_write_i_ram;
  end

  task automatic clear_queues();
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic expect_write(input int a, input logic [31:0] d);
    exp_addr.push_back(ADDR_WIDTH'(a));
    exp_data.push_back(d);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_n_writes"}, 32'(got_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
  endtask

  task automatic reset_dut();
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Presents one byte and returns at the negedge after it has been accepted.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (byte_ready !== 1'b1) check("byte_accept_timeout", 32'(byte_ready), 32'd1);
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n, input bit gap);
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (loading !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_end_timeout"}, 32'(loading), 32'd0);
  endtask

  function automatic logic [31:0] pattern(input int i);
    logic [7:0] b = 8'(i);
    return {b, b ^ 8'h5A, 8'(i * 7), ~b};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] wait_sz;

    // Reset state
    reset_dut();
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_flag", 32'(flag_write_i_ram), 32'd0);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_data", i_ram_input, 32'd0);
    check("rst_addr", 32'(i_ram_writing_address), 32'd0);

    // Two-word load with valid held high
    clear_queues();
    expect_write(0, 32'hDEADBEEF);
    expect_write(1, 32'h01234567);
    do_start();
    check("two_loading", 32'(loading), 32'd1);
    send_len(16'd2, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    send_word(32'h01234567, 1'b0);
    wait_end("two");
    check("two_done", 32'(done), 32'd1);
    check("two_error", 32'(error), 32'd0);
    check("two_ready", 32'(byte_ready), 32'd0);
    compare_writes("two");

    // Zero-length load
    clear_queues();
    do_start();
    check("zero_done_cleared", 32'(done), 32'd0);
    send_len(16'd0, 1'b0);
    wait_end("zero");
    check("zero_done", 32'(done), 32'd1);
    check("zero_error", 32'(error), 32'd0);
    compare_writes("zero");

    // Oversize length rejected; bytes in ERROR not consumed
    clear_queues();
    do_start();
    send_len(16'd32, 1'b0);
    wait_end("over");
    check("over_error", 32'(error), 32'd1);
    check("over_done", 32'(done), 32'd0);
    byte_in    = 8'hAB;
    byte_valid = 1'b1;
    repeat (3) @(negedge clock);
    check("over_ready", 32'(byte_ready), 32'd0);
    check("over_error_held", 32'(error), 32'd1);
    byte_valid = 1'b0;
    compare_writes("over");

    // Full-depth load with randomly gapped valid
    clear_queues();
    do_start();
    check("full_error_cleared", 32'(error), 32'd0);
    send_len(16'd31, 1'b1);
    for (int i = 0; i < 31; i++) begin
      expect_write(i, pattern(i));
      send_word(pattern(i), 1'b1);
    end
    wait_end("full");
    check("full_done", 32'(done), 32'd1);
    compare_writes("full");

    // Start pulsed mid-load is ignored
    clear_queues();
    expect_write(0, 32'hAABBCCDD);
    do_start();
    send_len(16'd1, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    do_start();
    check("mid_start_loading", 32'(loading), 32'd1);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    wait_end("mid");
    check("mid_done", 32'(done), 32'd1);
    compare_writes("mid");

    // Start in DONE begins a new load
    clear_queues();
    expect_write(0, 32'h12345678);
    do_start();
    check("restart_done", 32'(done), 32'd0);
    check("restart_loading", 32'(loading), 32'd1);
    send_len(16'd1, 1'b0);
    send_word(32'h12345678, 1'b0);
    wait_end("restart");
    check("restart_done_end", 32'(done), 32'd1);
    compare_writes("restart");

    // Reset during the WRITE cycle of word 1
    clear_queues();
    do_start();
    send_len(16'd2, 1'b0);
    send_word(32'h11223344, 1'b0);
    send_word(32'h55667788, 1'b0);
    check("rw_in_write", 32'(flag_write_i_ram), 32'd1);
    check("rw_addr", 32'(i_ram_writing_address), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rw_flag", 32'(flag_write_i_ram), 32'd0);
    check("rw_loading", 32'(loading), 32'd0);
    check("rw_done", 32'(done), 32'd0);
    check("rw_data", i_ram_input, 32'd0);
    check("rw_addr_rst", 32'(i_ram_writing_address), 32'd0);
    byte_in    = 8'h99;
    byte_valid = 1'b1;
    repeat (5) @(negedge clock);
    byte_valid = 1'b0;
    wait_sz = 32'(got_data.size());
    check("rw_no_more_strobe", wait_sz, 32'd2);
    check("rw_ready_idle", 32'(byte_ready), 32'd0);
    clear_queues();
    expect_write(0, 32'hCAFEBABE);
    do_start();
    send_len(16'd1, 1'b0);
    send_word(32'hCAFEBABE, 1'b0);
    wait_end("post_rst");
    check("post_rst_done", 32'(done), 32'd1);
    compare_writes("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 31, giving the number of instruction words the downstream instruction RAM holds (addresses 0..MEM_DEPTH-1).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, giving the write-address width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
REQ-006 byte_in  input  8  incoming program byte.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle; a byte transfers when byte_valid and byte_ready are both high at a rising edge.
REQ-009 i_ram_input  output  32  instruction word to the instruction RAM.
REQ-010 i_ram_writing_address  output  ADDR_WIDTH  instruction RAM write address.
REQ-011 flag_write_i_ram  output  1  one-cycle RAM write strobe.
REQ-012 loading  output  1  a load is in progress.
REQ-013 done  output  1  sticky: last load completed successfully.
REQ-014 error  output  1  sticky: last load rejected due to oversize length.

Function
REQ-015 The stream format SHALL be: 2-byte word count N (high byte first), then 4*N bytes, each word sent most-significant byte first.
REQ-016 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE and ERROR.
REQ-017 From IDLE, DONE or ERROR, start SHALL move the block to LEN_HI next cycle, clear done and error, and zero the word address and byte counter.
REQ-018 LEN_HI SHALL advance to LEN_LO on a byte transfer.
REQ-019 LEN_LO SHALL advance on a byte transfer: if N=0, to DONE; if N>MEM_DEPTH, to ERROR; otherwise to DATA.
REQ-020 In DATA, each transfer SHALL shift the byte into the assembly register (word = {word[23:0], byte_in}); the 4th byte SHALL move the block to WRITE.
REQ-021 WRITE SHALL last exactly one cycle with flag_write_i_ram=1, i_ram_input = the assembled word, and i_ram_writing_address = the current word index.
REQ-022 On leaving WRITE, the word index SHALL increment; the block goes to DONE if the index now equals N, otherwise back to DATA.
REQ-023 byte_ready SHALL be 1 exactly in LEN_HI, LEN_LO and DATA, and 0 in every other state, including WRITE.
REQ-024 Write latency SHALL be one cycle: the strobe is asserted in the cycle after the 4th byte of a word is accepted.
REQ-025 The word index SHALL never exceed MEM_DEPTH-1 when the strobe is asserted; there is no wrap-around.
REQ-026 flag_write_i_ram SHALL be 0 outside WRITE; i_ram_input and i_ram_writing_address SHALL hold their last values outside WRITE.
REQ-027 loading SHALL be 1 in LEN_HI, LEN_LO, DATA and WRITE.
REQ-028 done SHALL be 1 in DONE, and error SHALL be 1 in ERROR.
REQ-029 start SHALL be ignored while loading=1, and byte_valid SHALL be ignored while byte_ready=0.
REQ-030 Bytes presented in IDLE, DONE or ERROR SHALL NOT be consumed.

Reset
REQ-031 reset SHALL take priority over start and over any byte transfer in the same cycle.
REQ-032 Reset SHALL force state IDLE, byte_ready=0, flag_write_i_ram=0, loading=0, done=0, error=0, i_ram_input=0, i_ram_writing_address=0, word index 0 and byte counter 0.
REQ-033 Reset asserted during any state, including WRITE, SHALL abort the load within the same edge; no strobe SHALL follow reset.

Verification
REQ-034 Scenario: start, then bytes 00 02 DE AD BE EF 01 23 45 67 streamed with byte_valid held high -> two strobes: addr 0 = 0xDEADBEEF, addr 1 = 0x01234567, each one cycle; then done=1, loading=0.
REQ-035 Scenario: start, then bytes 00 00 -> done=1 with no strobe.
REQ-036 Scenario: start, then bytes 00 20 (N=32 > 31) -> error=1, no strobe, byte_ready=0 afterwards.
REQ-037 Scenario: N=31 with byte_valid toggled randomly -> 31 strobes at addresses 0..30 with correct words, byte_ready low during each WRITE cycle, and no transfer is lost or duplicated.
REQ-038 Scenario: reset asserted in the WRITE cycle of word 1 -> no further strobe and all outputs at reset values; a following start and valid 1-word load writes addr 0 correctly.
REQ-039 Scenario: start pulsed mid-load -> ignored and the load completes normally; start pulsed in DONE -> done clears and a new load begins.
